// File: rtl/montgomery.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, WIDTH+2 cycles per operation.
// Optional busy output is enabled by defining MONTGOMERY_BUSY_EN.
module montgomery #(
    parameter int unsigned WIDTH = 512
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done
`ifdef MONTGOMERY_BUSY_EN
    ,
    output logic             busy
`endif
);

    localparam int unsigned AW = WIDTH + 2;
    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOOP = 2'd1;
    localparam logic [1:0] S_SUB  = 2'd2;

    logic [1:0]       state, state_nx;
    logic [WIDTH-1:0] a_sh, a_nx;
    logic [WIDTH-1:0] b_r, b_nx;
    logic [WIDTH-1:0] m_r, m_nx;
    logic [AW-1:0]    c, c_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] result_nx;
    logic             done_nx;
    logic [AW-1:0]    t_add, t_odd;

    // Next-state and datapath; a is consumed LSB-first from a shift register.
    always_comb begin
        state_nx  = state;
        a_nx      = a_sh;
        b_nx      = b_r;
        m_nx      = m_r;
        c_nx      = c;
        cnt_nx    = cnt;
        result_nx = result;
        done_nx   = 1'b0;
        t_add     = c + (a_sh[0] ? {2'b00, b_r} : AW'(0));
        t_odd     = t_add[0] ? (t_add + {2'b00, m_r}) : t_add;
        case (state)
            S_IDLE: begin
                if (start) begin
                    a_nx     = in_a;
                    b_nx     = in_b;
                    m_nx     = in_m;
                    c_nx     = '0;
                    cnt_nx   = '0;
                    state_nx = S_LOOP;
                end
            end
            S_LOOP: begin
                c_nx   = t_odd >> 1;
                a_nx   = a_sh >> 1;
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(WIDTH - 1)) begin
                    state_nx = S_SUB;
                end
            end
            S_SUB: begin
                // C < 2m here, so one conditional subtraction fully reduces it.
                result_nx = (c >= {2'b00, m_r}) ? (c[WIDTH-1:0] - m_r) : c[WIDTH-1:0];
                done_nx   = 1'b1;
                state_nx  = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state  <= S_IDLE;
            a_sh   <= '0;
            b_r    <= '0;
            m_r    <= '0;
            c      <= '0;
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            a_sh   <= a_nx;
            b_r    <= b_nx;
            m_r    <= m_nx;
            c      <= c_nx;
            cnt    <= cnt_nx;
            result <= result_nx;
            done   <= done_nx;
        end
    end

`ifdef MONTGOMERY_BUSY_EN
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
        end
    end
`endif

endmodule

// File: tb/tb_montgomery.sv
// Directed self-checking bench for montgomery at WIDTH=512.
module tb_montgomery;

    localparam int unsigned W   = 512;
    localparam int          WIN = 530;

    localparam logic [W-1:0] VA = 512'hac4dc7bb86017e775bf3edb76f80426c4d898beafc672add50e1e2e2bb8a2c969ecc8fc5a23d1bd69e69b23d682b963d5995092569f4fad82e4e607b94e66799;
    localparam logic [W-1:0] VB = 512'hc4ab58ffd4d458dcd751e3453318a2490a75777890e826972f7650391eb8c239cd2d80add6e3376730d384a8967964ffbcc66e926e6b9105b527439e130b66f2;
    localparam logic [W-1:0] VM = 512'hcab66a300d7d7434e2eceed017d13eec8c2f3ea94f28e19cd436b45dc751ab45221998dbdf54698f675b04b08dfebe6c9327c6e6e6958ab181ced1fde03f2b63;
    localparam logic [W-1:0] VR = 512'h09888228681d45be403730f9b89ff217b61a3522008ab60428ad951bb5c6e4696b5937108813f3a03be712506188d051c1c255b16ebad379420eed9a97f800c0;
    localparam logic [W-1:0] ONES = {W{1'b1}};

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [W-1:0] in_a, in_b, in_m;
    logic [W-1:0] result;
    logic         done;
`ifdef MONTGOMERY_BUSY_EN
    logic         busy;
`endif

    int pass_cnt = 0;
    int total    = 0;

    montgomery #(.WIDTH(W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .in_a   (in_a),
        .in_b   (in_b),
        .in_m   (in_m),
        .result (result),
        .done   (done)
`ifdef MONTGOMERY_BUSY_EN
        ,
        .busy   (busy)
`endif
    );

    always #5 clk = ~clk;

    // Drive operands at a negedge, capture on the following posedge, then scramble the inputs.
    task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
        @(negedge clk);
        in_a  = a;
        in_b  = b;
        in_m  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a  = ~a;
        in_b  = {b[W-2:0], 1'b1};
        in_m  = '0;
    endtask

    // Watch WIN cycles after capture; cycle k is sampled at the k-th negedge.
    task automatic observe(input int inj1, input int inj2, input int inj3, input int rst_at,
                           output int first, output int pulses, output logic [W-1:0] res_done,
                           output logic [W-1:0] res_rst, output logic done_rst);
        first    = -1;
        pulses   = 0;
        res_done = 'x;
        res_rst  = 'x;
        done_rst = 1'bx;
        for (int k = 1; k <= WIN; k++) begin
            @(negedge clk);
            start = (k == inj1) || (k == inj2) || (k == inj3);
            if (start) begin
                in_a = 512'h2;
                in_b = 512'h3;
                in_m = ONES;
            end
            if (k == rst_at) resetn = 1'b1;
            if (k == rst_at + 2) resetn = 1'b0;
            #1;
            if (k == rst_at) begin
                res_rst  = result;
                done_rst = done;
            end
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first    = k;
                    res_done = result;
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        start  = 1'b0;
        in_a   = '0;
        in_b   = '0;
        in_m   = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (result !== '0) $display("FAIL reset_result got=%h want=0", result);
        else pass_cnt++;
        total++;
        if (done !== 1'b0) $display("FAIL reset_done got=%b want=0", done);
        else pass_cnt++;
`ifdef MONTGOMERY_BUSY_EN
        total++;
        if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy);
        else pass_cnt++;
`endif
        @(negedge clk);
        resetn = 1'b0;
    endtask

    task automatic test_vector();
        int first, pulses;
        logic [W-1:0] rd, rr;
        logic dr;
        do_start(VA, VB, VM);
`ifdef MONTGOMERY_BUSY_EN
        total++;
        if (busy !== 1'b1) $display("FAIL vec_busy got=%b want=1", busy);
        else pass_cnt++;
`endif
        observe(0, 0, 0, -10, first, pulses, rd, rr, dr);
        total++;
        if (first !== W + 2) $display("FAIL vec_latency got=%0d want=%0d", first, W + 2);
        else pass_cnt++;
        total++;
        if (pulses !== 1) $display("FAIL vec_pulses got=%0d want=1", pulses);
        else pass_cnt++;
        total++;
        if (rd !== VR) $display("FAIL vec_result got=%h want=%h", rd, VR);
        else pass_cnt++;
        total++;
        if (result !== VR) $display("FAIL vec_hold got=%h want=%h", result, VR);
        else pass_cnt++;
    endtask

    task automatic test_mod_ones();
        int first, pulses;
        logic [W-1:0] rd, rr;
        logic dr;
        do_start(512'h2, 512'h3, ONES);
        observe(0, 0, 0, -10, first, pulses, rd, rr, dr);
        total++;
        if (first !== W + 2) $display("FAIL ones_latency got=%0d want=%0d", first, W + 2);
        else pass_cnt++;
        total++;
        if (pulses !== 1) $display("FAIL ones_pulses got=%0d want=1", pulses);
        else pass_cnt++;
        total++;
        if (rd !== 512'h6) $display("FAIL ones_result got=%h want=6", rd);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        int first, pulses;
        logic [W-1:0] rd, rr;
        logic dr;
        do_start('0, VB, VM);
        observe(0, 0, 0, -10, first, pulses, rd, rr, dr);
        total++;
        if (pulses !== 1) $display("FAIL zero_pulses got=%0d want=1", pulses);
        else pass_cnt++;
        total++;
        if (rd !== '0) $display("FAIL zero_result got=%h want=0", rd);
        else pass_cnt++;
    endtask

    task automatic test_ignore_start();
        int first, pulses;
        logic [W-1:0] rd, rr;
        logic dr;
        do_start(VA, VB, VM);
        observe(10, 300, W + 1, -10, first, pulses, rd, rr, dr);
        total++;
        if (pulses !== 1) $display("FAIL ign_pulses got=%0d want=1", pulses);
        else pass_cnt++;
        total++;
        if (first !== W + 2) $display("FAIL ign_latency got=%0d want=%0d", first, W + 2);
        else pass_cnt++;
        total++;
        if (rd !== VR) $display("FAIL ign_result got=%h want=%h", rd, VR);
        else pass_cnt++;
    endtask

    task automatic test_abort();
        int first, pulses;
        logic [W-1:0] rd, rr;
        logic dr;
        do_start(VA, VB, VM);
        observe(0, 0, 0, 100, first, pulses, rd, rr, dr);
        total++;
        if (rr !== '0) $display("FAIL abort_async_result got=%h want=0", rr);
        else pass_cnt++;
        total++;
        if (dr !== 1'b0) $display("FAIL abort_async_done got=%b want=0", dr);
        else pass_cnt++;
        total++;
        if (pulses !== 0) $display("FAIL abort_pulses got=%0d want=0", pulses);
        else pass_cnt++;
        total++;
        if (result !== '0) $display("FAIL abort_result got=%h want=0", result);
        else pass_cnt++;
        do_start(512'h2, 512'h3, ONES);
        observe(0, 0, 0, -10, first, pulses, rd, rr, dr);
        total++;
        if (first !== W + 2 || pulses !== 1) $display("FAIL abort_restart_timing got=%0d/%0d want=%0d/1", first, pulses, W + 2);
        else pass_cnt++;
        total++;
        if (rd !== 512'h6) $display("FAIL abort_restart_result got=%h want=6", rd);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int first, pulses, waited;
        logic [W-1:0] rd, rr;
        logic dr;
        do_start(512'h2, 512'h3, ONES);
        waited = 0;
        @(negedge clk);
        while (done !== 1'b1 && waited < WIN) begin
            @(negedge clk);
            waited++;
        end
        total++;
        if (done !== 1'b1) $display("FAIL b2b_first_done got=%b want=1", done);
        else pass_cnt++;
        in_a  = VA;
        in_b  = VB;
        in_m  = VM;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_a  = '0;
`ifdef MONTGOMERY_BUSY_EN
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_busy got=%b want=1", busy);
        else pass_cnt++;
`endif
        total++;
        if (result !== 512'h6) $display("FAIL b2b_hold got=%h want=6", result);
        else pass_cnt++;
        observe(0, 0, 0, -10, first, pulses, rd, rr, dr);
        total++;
        if (first !== W + 2 || pulses !== 1) $display("FAIL b2b_timing got=%0d/%0d want=%0d/1", first, pulses, W + 2);
        else pass_cnt++;
        total++;
        if (rd !== VR) $display("FAIL b2b_result got=%h want=%h", rd, VR);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_vector();
        test_mod_ones();
        test_zero();
        test_ignore_start();
        test_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/montgomery.md
MONTGOMERY -- requirements
Module: montgomery

Interface
REQ-001 Parameter: WIDTH, default 512, operand/modulus/result width in bits; all vectors below are WIDTH bits wide.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 resetn  input  1  reset, asynchronous, active-high (asserted when 1, despite the name).
REQ-004 start  input  1  one-cycle request pulse; operands are captured on the rising edge where start=1 and the block is idle.
REQ-005 in_a  input  WIDTH  multiplicand a, with a < m.
REQ-006 in_b  input  WIDTH  multiplier b, with b < m.
REQ-007 in_m  input  WIDTH  modulus m; odd, with m >= 3.
REQ-008 result  output  WIDTH  a*b*2^-WIDTH mod m, fully reduced into the range [0, m).
REQ-009 done  output  1  one-cycle pulse; result is valid while done=1 and is held afterwards.

Function
REQ-010 The block SHALL use a three-state FSM: IDLE, LOOP and SUB.
- IDLE -> LOOP on start=1.
- LOOP -> SUB after exactly WIDTH iterations.
- SUB -> IDLE after one cycle.
REQ-011 In IDLE with start=1, the block SHALL latch in_a, in_b and in_m, clear the accumulator C and the bit counter, and enter LOOP.
REQ-012 Each LOOP cycle i (i = 0..WIDTH-1) SHALL perform one radix-2 step: T = C + a[i]*b; if T is odd, T = T + m; C = T >> 1.
REQ-013 The accumulator and adders SHALL be WIDTH+2 bits wide so that C + b + m < 4m never overflows.
REQ-014 In SUB, the block SHALL compute result = (C >= m) ? C - m : C, register it, and assert done for that single following cycle.
REQ-015 Latency: done SHALL be high in the (WIDTH+2)th cycle after the capturing edge (cycle 514 for WIDTH=512), and low in every other cycle.
REQ-016 start SHALL be ignored while in LOOP or SUB; the input ports may change freely after capture without affecting the operation.
REQ-017 result SHALL hold its last value until the next done pulse; if start=1 in the same cycle done=1, a new operation begins normally.
REQ-018 Operands violating REQ-005..007 SHALL still complete in WIDTH+2 cycles; the result value is unspecified in that case.

Reset
REQ-019 While resetn=1: FSM = IDLE, result = 0, done = 0, C = 0, counter = 0, all applied immediately (asynchronously).
REQ-020 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after reset release is accepted.

Configuration
REQ-021 Macro MONTGOMERY_BUSY_EN:
- Defined: adds output busy (1 bit), high in LOOP and SUB and low in IDLE and during reset.
- Undefined: no busy port exists.
- All other behaviour is identical in both cases.

Verification
REQ-022 Vector, WIDTH=512 -> after done, result = 09888228681d45be403730f9b89ff217b61a3522008ab60428ad951bb5c6e4696b5937108813f3a03be712506188d051c1c255b16ebad379420eed9a97f800c0.
- a = ac4dc7bb86017e775bf3edb76f80426c4d898beafc672add50e1e2e2bb8a2c969ecc8fc5a23d1bd69e69b23d682b963d5995092569f4fad82e4e607b94e66799
- b = c4ab58ffd4d458dcd751e3453318a2490a75777890e826972f7650391eb8c239cd2d80add6e3376730d384a8967964ffbcc66e926e6b9105b527439e130b66f2
- m = cab66a300d7d7434e2eceed017d13eec8c2f3ea94f28e19cd436b45dc751ab45221998dbdf54698f675b04b08dfebe6c9327c6e6e6958ab181ced1fde03f2b63
REQ-023 m = 2^512-1, a = 2, b = 3 -> result = 6, with done high exactly 514 cycles after the start edge.
REQ-024 a = 0, b = any value below m, m = the modulus from REQ-022 -> result = 0 with a single done pulse.
REQ-025 Start pulses issued during LOOP -> ignored; exactly one done pulse, and result still matches REQ-022.
REQ-026 resetn=1 for 2 cycles at cycle 100 of an operation -> no done pulse, result = 0; a restart then yields the REQ-023 result.
